// File: rtl/cpu_pkg.sv
// Shared widths, interrupt vector and call/return FSM encoding for the core, stack and sequencer.
package cpu_pkg;

    localparam int unsigned CPU_DATA_WIDTH = 16;
    localparam int unsigned CPU_ADDR_WIDTH = 10;
    localparam int unsigned CPU_MEM_SIZE   = 64;
    localparam int unsigned CPU_SP_WIDTH   = 6;
    localparam int unsigned CPU_FLAG_WIDTH = 4;

    localparam logic [CPU_ADDR_WIDTH-1:0] CPU_IRQ_VECTOR = 10'h3F0;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CALL_PUSH   = 3'd1,
        S_IRQ_PUSH_PC = 3'd2,
        S_IRQ_PUSH_FL = 3'd3,
        S_RET_POP     = 3'd4,
        S_RETI_POP_FL = 3'd5,
        S_RETI_POP_PC = 3'd6,
        S_POP_LOAD    = 3'd7
    } seq_state_e;

endpackage

// File: rtl/stack_call_ctrl.sv
// Call/return sequencer: turns CALL/RET/IRQ/RETI into push/pop cycles on the
// hardware return stack, reloads PC/flags from popped words, and flags
// overflow/underflow before the stack is touched.
module stack_call_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int unsigned MEM_SIZE   = CPU_MEM_SIZE,
    parameter int unsigned SP_WIDTH   = CPU_SP_WIDTH,
    parameter int unsigned FLAG_WIDTH = CPU_FLAG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = CPU_IRQ_VECTOR
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCall,
    input  logic                  iRet,
    input  logic                  iIrq,
    input  logic                  iReti,
    input  logic                  iClearErr,
    input  logic [ADDR_WIDTH-1:0] iPC,
    input  logic [ADDR_WIDTH-1:0] iTarget,
    input  logic [FLAG_WIDTH-1:0] iFlags,
    input  logic [DATA_WIDTH-1:0] iStackTop,
    input  logic [SP_WIDTH-1:0]   iStackPointer,
    output logic                  oStackWrite,
    output logic                  oStackRead,
    output logic [DATA_WIDTH-1:0] oStackData,
    output logic                  oPCLoad,
    output logic [ADDR_WIDTH-1:0] oPCOut,
    output logic                  oFlagsLoad,
    output logic [FLAG_WIDTH-1:0] oFlagsOut,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam logic [SP_WIDTH-1:0] SP_CALL_LIMIT = SP_WIDTH'(MEM_SIZE - 1);
    localparam logic [SP_WIDTH-1:0] SP_IRQ_LIMIT  = SP_WIDTH'(MEM_SIZE - 2);
    localparam logic [SP_WIDTH-1:0] SP_ONE        = SP_WIDTH'(1);
    localparam logic [SP_WIDTH-1:0] SP_TWO        = SP_WIDTH'(2);

    seq_state_e            state_q;
    logic [FLAG_WIDTH-1:0] irq_flags_q;

    logic call_ok_c;
    logic irq_ok_c;
    logic ret_ok_c;
    logic reti_ok_c;

    // Popped words only carry PC/flags in their low bits; the upper bits are don't-care.
    logic unused_top_hi;
    assign unused_top_hi = ^iStackTop[DATA_WIDTH-1:ADDR_WIDTH];

    // Capacity checks against the live stack pointer, evaluated while idle.
    always_comb begin
        call_ok_c = 1'b0;
        irq_ok_c  = 1'b0;
        ret_ok_c  = 1'b0;
        reti_ok_c = 1'b0;
        call_ok_c = (iStackPointer < SP_CALL_LIMIT);
        irq_ok_c  = (iStackPointer < SP_IRQ_LIMIT);
        ret_ok_c  = (iStackPointer >= SP_ONE);
        reti_ok_c = (iStackPointer >= SP_TWO);
    end

    // Sequencer FSM; outputs for the next cycle are registered on each transition.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            irq_flags_q <= '0;
            oStackWrite <= 1'b0;
            oStackRead  <= 1'b0;
            oStackData  <= '0;
            oPCLoad     <= 1'b0;
            oPCOut      <= '0;
            oFlagsLoad  <= 1'b0;
            oFlagsOut   <= '0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oOverflow   <= 1'b0;
            oUnderflow  <= 1'b0;
        end else begin
            oStackWrite <= 1'b0;
            oStackRead  <= 1'b0;
            oPCLoad     <= 1'b0;
            oFlagsLoad  <= 1'b0;
            oDone       <= 1'b0;
            oBusy       <= 1'b0;
            // Clear first so that a set later in this block takes precedence.
            if (iClearErr) begin
                oOverflow  <= 1'b0;
                oUnderflow <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (iIrq) begin
                        if (irq_ok_c) begin
                            irq_flags_q <= iFlags;
                            oStackWrite <= 1'b1;
                            oStackData  <= DATA_WIDTH'(iPC);
                            oBusy       <= 1'b1;
                            state_q     <= S_IRQ_PUSH_PC;
                        end else begin
                            oOverflow <= 1'b1;
                            oDone     <= 1'b1;
                        end
                    end else if (iReti) begin
                        if (reti_ok_c) begin
                            oStackRead <= 1'b1;
                            oBusy      <= 1'b1;
                            state_q    <= S_RETI_POP_FL;
                        end else begin
                            oUnderflow <= 1'b1;
                            oDone      <= 1'b1;
                        end
                    end else if (iRet) begin
                        if (ret_ok_c) begin
                            oStackRead <= 1'b1;
                            oBusy      <= 1'b1;
                            state_q    <= S_RET_POP;
                        end else begin
                            oUnderflow <= 1'b1;
                            oDone      <= 1'b1;
                        end
                    end else if (iCall) begin
                        if (call_ok_c) begin
                            oStackWrite <= 1'b1;
                            oStackData  <= DATA_WIDTH'(iPC);
                            oPCLoad     <= 1'b1;
                            oPCOut      <= iTarget;
                            oDone       <= 1'b1;
                            oBusy       <= 1'b1;
                            state_q     <= S_CALL_PUSH;
                        end else begin
                            oOverflow <= 1'b1;
                            oDone     <= 1'b1;
                        end
                    end
                end
                S_IRQ_PUSH_PC: begin
                    oStackWrite <= 1'b1;
                    oStackData  <= DATA_WIDTH'(irq_flags_q);
                    oPCLoad     <= 1'b1;
                    oPCOut      <= IRQ_VECTOR;
                    oDone       <= 1'b1;
                    oBusy       <= 1'b1;
                    state_q     <= S_IRQ_PUSH_FL;
                end
                S_RET_POP: begin
                    oPCLoad <= 1'b1;
                    oPCOut  <= iStackTop[ADDR_WIDTH-1:0];
                    oDone   <= 1'b1;
                    oBusy   <= 1'b1;
                    state_q <= S_POP_LOAD;
                end
                S_RETI_POP_FL: begin
                    oFlagsLoad <= 1'b1;
                    oFlagsOut  <= iStackTop[FLAG_WIDTH-1:0];
                    oStackRead <= 1'b1;
                    oBusy      <= 1'b1;
                    state_q    <= S_RETI_POP_PC;
                end
                S_RETI_POP_PC: begin
                    oPCLoad <= 1'b1;
                    oPCOut  <= iStackTop[ADDR_WIDTH-1:0];
                    oDone   <= 1'b1;
                    oBusy   <= 1'b1;
                    state_q <= S_POP_LOAD;
                end
                S_CALL_PUSH,
                S_IRQ_PUSH_FL,
                S_POP_LOAD: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Directed bench for stack_call_ctrl with a behavioural return stack model.
module tb_stack_call_ctrl;

    logic        Clock;
    logic        Reset;
    logic        iCall, iRet, iIrq, iReti, iClearErr;
    logic [9:0]  iPC, iTarget;
    logic [3:0]  iFlags;
    logic [15:0] iStackTop;
    logic [5:0]  iStackPointer;
    logic        oStackWrite, oStackRead;
    logic [15:0] oStackData;
    logic        oPCLoad;
    logic [9:0]  oPCOut;
    logic        oFlagsLoad;
    logic [3:0]  oFlagsOut;
    logic        oBusy, oDone, oOverflow, oUnderflow;

    int checks   = 0;
    int failures = 0;

    // Stack model: preload port for the bench, otherwise saturating push/pop.
    logic [15:0] mem [0:63];
    logic [5:0]  sp;
    logic        sp_load;
    logic [5:0]  sp_val;

    stack_call_ctrl dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iCall        (iCall),
        .iRet         (iRet),
        .iIrq         (iIrq),
        .iReti        (iReti),
        .iClearErr    (iClearErr),
        .iPC          (iPC),
        .iTarget      (iTarget),
        .iFlags       (iFlags),
        .iStackTop    (iStackTop),
        .iStackPointer(iStackPointer),
        .oStackWrite  (oStackWrite),
        .oStackRead   (oStackRead),
        .oStackData   (oStackData),
        .oPCLoad      (oPCLoad),
        .oPCOut       (oPCOut),
        .oFlagsLoad   (oFlagsLoad),
        .oFlagsOut    (oFlagsOut),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (sp_load) begin
            sp <= sp_val;
        end else if (oStackWrite && sp < 6'd63) begin
            mem[sp] <= oStackData;
            sp      <= sp + 6'd1;
        end else if (oStackRead && sp > 6'd0) begin
            sp <= sp - 6'd1;
        end
    end

    always_comb begin
        iStackPointer = sp;
        iStackTop     = (sp == 6'd0) ? 16'h0000 : mem[sp - 6'd1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_reqs();
        iCall = 1'b0; iRet = 1'b0; iIrq = 1'b0; iReti = 1'b0;
    endtask

    task automatic set_sp(input logic [5:0] v);
        sp_load = 1'b1;
        sp_val  = v;
        step();
        sp_load = 1'b0;
    endtask

    logic [38:0] all_outs;
    assign all_outs = {oStackWrite, oStackRead, oStackData, oPCLoad, oPCOut,
                       oFlagsLoad, oFlagsOut, oBusy, oDone, oOverflow, oUnderflow, 1'b0};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        sp = 6'd0;
        sp_load = 1'b0; sp_val = 6'd0;
        Reset = 1'b0;
        clear_reqs();
        iClearErr = 1'b0;
        iPC = '0; iTarget = '0; iFlags = '0;

        // Reset state
        step(); step();
        check("reset_outputs", 64'(all_outs), 64'd0);
        Reset = 1'b1;
        set_sp(6'd0);

        // CALL from empty stack
        iCall = 1'b1; iPC = 10'h012; iTarget = 10'h100;
        step(); clear_reqs();
        check("call_write", 64'(oStackWrite), 64'd1);
        check("call_data", 64'(oStackData), 64'h0012);
        check("call_pcload", 64'(oPCLoad), 64'd1);
        check("call_pcout", 64'(oPCOut), 64'h100);
        check("call_done", 64'(oDone), 64'd1);
        check("call_busy", 64'(oBusy), 64'd1);
        step();
        check("call_end_write", 64'(oStackWrite), 64'd0);
        check("call_end_busy", 64'(oBusy), 64'd0);
        check("call_sp", 64'(sp), 64'd1);

        // RET back to caller
        iRet = 1'b1;
        step(); clear_reqs();
        check("ret_read", 64'(oStackRead), 64'd1);
        check("ret_n1_done", 64'(oDone), 64'd0);
        check("ret_n1_pcload", 64'(oPCLoad), 64'd0);
        step();
        check("ret_read_off", 64'(oStackRead), 64'd0);
        check("ret_pcload", 64'(oPCLoad), 64'd1);
        check("ret_pcout", 64'(oPCOut), 64'h012);
        check("ret_done", 64'(oDone), 64'd1);
        check("ret_sp", 64'(sp), 64'd0);
        step();
        check("ret_end_busy", 64'(oBusy), 64'd0);

        // IRQ entry at SP=3
        set_sp(6'd3);
        iIrq = 1'b1; iPC = 10'h055; iFlags = 4'hA;
        step(); clear_reqs();
        check("irq_n1_write", 64'(oStackWrite), 64'd1);
        check("irq_n1_data", 64'(oStackData), 64'h0055);
        check("irq_n1_pcload", 64'(oPCLoad), 64'd0);
        step();
        check("irq_n2_write", 64'(oStackWrite), 64'd1);
        check("irq_n2_data", 64'(oStackData), 64'h000A);
        check("irq_n2_pcload", 64'(oPCLoad), 64'd1);
        check("irq_n2_pcout", 64'(oPCOut), 64'h3F0);
        check("irq_n2_done", 64'(oDone), 64'd1);
        step();
        check("irq_end_busy", 64'(oBusy), 64'd0);
        check("irq_sp", 64'(sp), 64'd5);

        // RETI restores flags then PC
        iReti = 1'b1;
        step(); clear_reqs();
        check("reti_n1_read", 64'(oStackRead), 64'd1);
        step();
        check("reti_n2_read", 64'(oStackRead), 64'd1);
        check("reti_n2_flagsload", 64'(oFlagsLoad), 64'd1);
        check("reti_n2_flagsout", 64'(oFlagsOut), 64'hA);
        check("reti_n2_done", 64'(oDone), 64'd0);
        step();
        check("reti_n3_read", 64'(oStackRead), 64'd0);
        check("reti_n3_flagsload", 64'(oFlagsLoad), 64'd0);
        check("reti_n3_pcload", 64'(oPCLoad), 64'd1);
        check("reti_n3_pcout", 64'(oPCOut), 64'h055);
        check("reti_n3_done", 64'(oDone), 64'd1);
        check("reti_sp", 64'(sp), 64'd3);
        step();

        // Overflow on CALL at SP=63
        set_sp(6'd63);
        iCall = 1'b1; iTarget = 10'h200;
        step(); clear_reqs();
        check("ovf_call_write", 64'(oStackWrite), 64'd0);
        check("ovf_call_pcload", 64'(oPCLoad), 64'd0);
        check("ovf_call_flag", 64'(oOverflow), 64'd1);
        check("ovf_call_done", 64'(oDone), 64'd1);
        check("ovf_call_busy", 64'(oBusy), 64'd0);
        step();
        check("ovf_sticky", 64'(oOverflow), 64'd1);
        check("ovf_done_pulse", 64'(oDone), 64'd0);
        iClearErr = 1'b1;
        step();
        iClearErr = 1'b0;
        check("ovf_cleared", 64'(oOverflow), 64'd0);

        // Overflow on IRQ at SP=62 with clear held: set wins
        set_sp(6'd62);
        iIrq = 1'b1; iClearErr = 1'b1;
        step(); clear_reqs();
        check("ovf_irq_write", 64'(oStackWrite), 64'd0);
        check("ovf_irq_flag_vs_clear", 64'(oOverflow), 64'd1);
        check("ovf_irq_done", 64'(oDone), 64'd1);
        step();
        iClearErr = 1'b0;
        check("ovf_irq_cleared", 64'(oOverflow), 64'd0);

        // Underflow on RET at SP=0 and RETI at SP=1
        set_sp(6'd0);
        iRet = 1'b1;
        step(); clear_reqs();
        check("unf_ret_read", 64'(oStackRead), 64'd0);
        check("unf_ret_flag", 64'(oUnderflow), 64'd1);
        check("unf_ret_done", 64'(oDone), 64'd1);
        iClearErr = 1'b1;
        step();
        iClearErr = 1'b0;
        check("unf_cleared", 64'(oUnderflow), 64'd0);
        set_sp(6'd1);
        iReti = 1'b1;
        step(); clear_reqs();
        check("unf_reti_read", 64'(oStackRead), 64'd0);
        check("unf_reti_flag", 64'(oUnderflow), 64'd1);
        check("unf_reti_ovf_clear", 64'(oOverflow), 64'd0);
        iClearErr = 1'b1;
        step();
        iClearErr = 1'b0;

        // IRQ beats CALL; CALL during busy is ignored
        set_sp(6'd0);
        iIrq = 1'b1; iCall = 1'b1; iPC = 10'h0AA; iFlags = 4'h5; iTarget = 10'h2BC;
        step(); clear_reqs();
        check("prio_write", 64'(oStackWrite), 64'd1);
        check("prio_data", 64'(oStackData), 64'h00AA);
        check("prio_no_call_load", 64'(oPCLoad), 64'd0);
        iCall = 1'b1;
        step(); clear_reqs();
        check("prio_fl_data", 64'(oStackData), 64'h0005);
        check("prio_fl_pcout", 64'(oPCOut), 64'h3F0);
        step();
        check("busy_ignore_write", 64'(oStackWrite), 64'd0);
        check("busy_ignore_pcload", 64'(oPCLoad), 64'd0);
        check("busy_ignore_busy", 64'(oBusy), 64'd0);
        check("prio_sp", 64'(sp), 64'd2);

        // Reset asserted in RETI_POP_PC abandons the sequence
        iReti = 1'b1;
        step(); clear_reqs();
        step();
        check("rst_pre_flagsload", 64'(oFlagsLoad), 64'd1);
        Reset = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(all_outs), 64'd0);
        step();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_after_pcload", 64'(oPCLoad), 64'd0);
            check("rst_after_busy", 64'(oBusy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_call_ctrl.md
Name: stack_call_ctrl

Overview:
Call/return sequencer that drives the 16-bit hardware return stack on behalf of the CPU core. It turns CALL, RET, interrupt entry (IRQ) and interrupt return (RETI) into push/pop cycles on the stack's write/read strobes. It loads the program counter and flags from popped data and stalls the core while a sequence is in flight. It also detects overflow/underflow before touching the stack, because the stack itself only saturates silently.

Parameters:
DATA_WIDTH, 16, stack word width
ADDR_WIDTH, 10, program counter width (≤ DATA_WIDTH)
MEM_SIZE, 64, stack depth; usable capacity is MEM_SIZE-1 entries
SP_WIDTH, 6, stack pointer width
FLAG_WIDTH, 4, status flag width (≤ DATA_WIDTH)
IRQ_VECTOR, 10'h3F0, PC loaded on interrupt entry

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
iCall  in  1  CALL request pulse
iRet  in  1  RET request pulse
iIrq  in  1  interrupt entry request pulse
iReti  in  1  interrupt return request pulse
iClearErr  in  1  clears sticky error flags
iPC  in  ADDR_WIDTH  return address; captured on accept
iTarget  in  ADDR_WIDTH  CALL destination; captured on accept
iFlags  in  FLAG_WIDTH  core flags; captured on IRQ accept
iStackTop  in  DATA_WIDTH  combinational top-of-stack from the stack
iStackPointer  in  SP_WIDTH  current stack pointer from the stack
oStackWrite  out  1  push strobe to stack
oStackRead  out  1  pop strobe to stack
oStackData  out  DATA_WIDTH  push data
oPCLoad  out  1  one-cycle PC load strobe
oPCOut  out  ADDR_WIDTH  PC value for oPCLoad
oFlagsLoad  out  1  one-cycle flags restore strobe
oFlagsOut  out  FLAG_WIDTH  restored flags
oBusy  out  1  high whenever state != IDLE
oDone  out  1  one-cycle sequence-complete pulse
oOverflow  out  1  sticky overflow
oUnderflow  out  1  sticky underflow

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low. While Reset=0, state=IDLE and every output is 0, including the sticky flags.
- Reset mid-sequence: the sequence is abandoned and no further strobes are issued. The stack is reset independently.
- All outputs are registered.
- Request sampling: requests are sampled only in IDLE and are ignored while oBusy=1. Priority: iIrq > iReti > iRet > iCall; lower-priority requests in the same cycle are dropped.
- Data packing: pushed words are zero-extended. Popped PC = iStackTop[ADDR_WIDTH-1:0]; popped flags = iStackTop[FLAG_WIDTH-1:0].
- Capacity checks are done in IDLE against iStackPointer (call the value SP):
  - CALL needs SP < MEM_SIZE-1.
  - IRQ needs SP < MEM_SIZE-2.
  - RET needs SP ≥ 1.
  - RETI needs SP ≥ 2.
  - On a failed check: no stack strobe and no load. The matching sticky flag and oDone go high in N+1, and the FSM stays in IDLE.
- Timing is relative to accept cycle N:
  - CALL (state CALL_PUSH), N+1: oStackWrite=1, oStackData=iPC, oPCLoad=1, oPCOut=iTarget, oDone=1.
  - IRQ (IRQ_PUSH_PC → IRQ_PUSH_FL):
    - N+1: push iPC.
    - N+2: push iFlags, oPCLoad=1, oPCOut=IRQ_VECTOR, oDone=1.
  - RET (RET_POP → POP_LOAD):
    - N+1: oStackRead=1, and iStackTop is captured at the end of that cycle.
    - N+2: oPCLoad=1 with the captured PC, oDone=1.
  - RETI (RETI_POP_FL → RETI_POP_PC → POP_LOAD):
    - N+1: pop flags.
    - N+2: pop PC, oFlagsLoad=1.
    - N+3: oPCLoad=1, oDone=1.
- States: IDLE, CALL_PUSH, IRQ_PUSH_PC, IRQ_PUSH_FL, RET_POP, RETI_POP_FL, RETI_POP_PC, POP_LOAD. Every non-IDLE state lasts exactly one cycle. The final state returns to IDLE.
- Strobes: oStackWrite and oStackRead are never high together, and each lasts exactly one cycle per push or pop.
- Back-to-back sequences: the stack pointer updates on the edge ending a strobe cycle, so a request accepted in the first IDLE cycle after oDone sees the updated pointer.
- Sticky flags: a set wins over a simultaneous iClearErr.

Decomposition:
- Shared package (cpu_pkg): FSM state encoding constants, IRQ_VECTOR, and the DATA/ADDR/FLAG/SP widths, so they are shared with the stack and the core.
- No sub-module: one FSM plus capture registers.

Test Plan:
- SP=0, iCall, iPC=10'h012, iTarget=10'h100 → N+1: write=1, data=16'h0012, PCLoad=1, PCOut=10'h100, done=1; next-cycle SP=1.
- After the above, iRet → N+1: read=1; N+2: PCLoad=1, PCOut=10'h012; SP returns to 0.
- SP=3, iIrq, iPC=10'h055, iFlags=4'hA → N+1: push 16'h0055; N+2: push 16'h000A, PCOut=10'h3F0. Then iReti → N+2: FlagsLoad, FlagsOut=4'hA; N+3: PCOut=10'h055; SP back to 3.
- SP=63 with iCall, and SP=62 with iIrq → no write, oOverflow=1 at N+1, done=1. iClearErr → flag clears. iClearErr held with a new overflow → flag stays 1.
- SP=0 with iRet, and SP=1 with iReti → no read, oUnderflow=1.
- iIrq and iCall in the same cycle → only the IRQ sequence runs. A request during busy is ignored. Reset=0 asserted in RETI_POP_PC → all outputs 0, no PCLoad after release.
